// File: rtl/rover_pkg.sv
// Shared types for the land-rover room FSM and its downstream monitor.
// Room codes and monitor states live here so both sides agree on encoding.
package rover_pkg;

    typedef logic [2:0] room_t;

    localparam int NUM_ROOMS = 8;

    localparam room_t ROOM0 = 3'd0;
    localparam room_t ROOM1 = 3'd1;
    localparam room_t ROOM2 = 3'd2;
    localparam room_t ROOM3 = 3'd3;
    localparam room_t ROOM4 = 3'd4;
    localparam room_t ROOM5 = 3'd5;
    localparam room_t ROOM6 = 3'd6;
    localparam room_t ROOM7 = 3'd7;

    typedef enum logic {
        TRACK = 1'b0,
        STUCK = 1'b1
    } mon_state_t;

endpackage

// File: rtl/rover_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
// Used for both per-room visit counts and the dwell timer.
module rover_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/rover_room_monitor.sv
// Watches the room FSM code: counts visits, times dwell, flags a stuck rover
// and reports each room change as a handshaked event record.
module rover_room_monitor
    import rover_pkg::*;
#(
    parameter int DWELL_W     = 8,
    parameter int CNT_W       = 8,
    parameter int STUCK_LIMIT = 200
) (
    input  logic               clk,
    input  logic               reset_n,
    input  room_t              room,
    input  room_t              goal_room,
    input  logic               clear,
    input  logic               evt_ready,
    output logic               evt_valid,
    output room_t              evt_prev,
    output room_t              evt_room,
    output logic [DWELL_W-1:0] evt_dwell,
    output logic               evt_overflow,
    output logic               goal_hit,
    output logic               stuck,
    input  room_t              q_room,
    output logic [CNT_W-1:0]   q_count
);

    room_t              cur_room;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_inc;
    logic [CNT_W-1:0]   visit [NUM_ROOMS];
    mon_state_t         state_q;
    mon_state_t         state_d;
    logic               trans;
    logic               load;
    logic               drop;

    // A clear cycle never counts as a transition, even if the room moved.
    assign trans     = !clear && (room != cur_room);
    assign load      = trans && (!evt_valid || evt_ready);
    assign drop      = trans && evt_valid && !evt_ready;
    assign dwell_inc = (dwell == '1) ? dwell : dwell + DWELL_W'(1);
    assign stuck     = (state_q == STUCK);

    rover_sat_counter #(
        .W(DWELL_W)
    ) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear || trans),
        .inc     (!clear && !trans),
        .q       (dwell)
    );

    for (genvar i = 0; i < NUM_ROOMS; i++) begin : g_visit
        rover_sat_counter #(
            .W(CNT_W)
        ) u_visit (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clear),
            .inc     (trans && (room == room_t'(i))),
            .q       (visit[i])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TRACK: begin
                if (!clear && !trans &&
                    (dwell_inc == DWELL_W'(STUCK_LIMIT))) begin
                    state_d = STUCK;
                end
            end
            STUCK: begin
                if (clear || trans) begin
                    state_d = TRACK;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_room     <= ROOM0;
            state_q      <= TRACK;
            evt_valid    <= 1'b0;
            evt_prev     <= ROOM0;
            evt_room     <= ROOM0;
            evt_dwell    <= '0;
            evt_overflow <= 1'b0;
            goal_hit     <= 1'b0;
            q_count      <= '0;
        end else begin
            state_q  <= state_d;
            q_count  <= visit[q_room];
            goal_hit <= trans && (room == goal_room);
            if (clear) begin
                cur_room     <= room;
                evt_valid    <= 1'b0;
                evt_overflow <= 1'b0;
            end else begin
                if (trans) begin
                    cur_room <= room;
                end
                // Held record stays frozen until the logger takes it.
                if (load) begin
                    evt_valid <= 1'b1;
                    evt_prev  <= cur_room;
                    evt_room  <= room;
                    evt_dwell <= dwell;
                end else if (evt_valid && evt_ready) begin
                    evt_valid <= 1'b0;
                end
                if (drop) begin
                    evt_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rover_room_monitor.sv
// Bench for rover_room_monitor: scoreboarded event stream plus
// table-driven goal checks and hand sequences for drop, stuck, clear, reset.
module tb_rover_room_monitor;

    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int LIM = 200;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic [2:0]    room      = 3'd0;
    logic [2:0]    goal_room = 3'd7;
    logic          clear     = 1'b0;
    logic          evt_ready = 1'b1;
    logic [2:0]    q_room    = 3'd0;
    logic          evt_valid;
    logic [2:0]    evt_prev;
    logic [2:0]    evt_room;
    logic [DW-1:0] evt_dwell;
    logic          evt_overflow;
    logic          goal_hit;
    logic          stuck;
    logic [CW-1:0] q_count;

    always #5 clk = ~clk;

    rover_room_monitor #(
        .DWELL_W     (DW),
        .CNT_W       (CW),
        .STUCK_LIMIT (LIM)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .room         (room),
        .goal_room    (goal_room),
        .clear        (clear),
        .evt_ready    (evt_ready),
        .evt_valid    (evt_valid),
        .evt_prev     (evt_prev),
        .evt_room     (evt_room),
        .evt_dwell    (evt_dwell),
        .evt_overflow (evt_overflow),
        .goal_hit     (goal_hit),
        .stuck        (stuck),
        .q_room       (q_room),
        .q_count      (q_count)
    );

    typedef struct packed {
        logic [2:0] prev;
        logic [2:0] rm;
        logic [7:0] dw;
    } evt_t;

    typedef struct {
        logic [2:0] room;
        logic       exp_goal;
        logic       exp_valid;
    } vec_t;

    evt_t       exp_q[$];
    vec_t       tbl[6];
    int         checks   = 0;
    int         failures = 0;
    logic [2:0] m_cur    = 3'd0;
    int         m_dwell  = 0;
    int         m_visit[8];
    logic       push_en  = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, evt_valid, 0);
        chk({tag, "_prev"}, evt_prev, 0);
        chk({tag, "_room"}, evt_room, 0);
        chk({tag, "_dwell"}, evt_dwell, 0);
        chk({tag, "_ovf"}, evt_overflow, 0);
        chk({tag, "_goal"}, goal_hit, 0);
        chk({tag, "_stuck"}, stuck, 0);
        chk({tag, "_qcnt"}, q_count, 0);
    endtask

    // One clock: update the reference, push expected events, then
    // compare every newly presented event against the queue head.
    task automatic tick();
        logic pv;
        logic hs;
        int   exp_qc;
        evt_t e;
        pv     = evt_valid;
        hs     = evt_valid && evt_ready;
        exp_qc = m_visit[q_room];
        if (clear) begin
            m_cur   = room;
            m_dwell = 0;
            foreach (m_visit[i]) m_visit[i] = 0;
        end else if (room != m_cur) begin
            if (push_en) begin
                e.prev = m_cur;
                e.rm   = room;
                e.dw   = 8'(m_dwell);
                exp_q.push_back(e);
            end
            if (m_visit[room] < 255) m_visit[room]++;
            m_cur   = room;
            m_dwell = 0;
        end else if (m_dwell < 255) begin
            m_dwell++;
        end
        @(posedge clk);
        #1;
        chk("q_count", q_count, exp_qc);
        if (evt_valid && (!pv || hs)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL evt_unexpected: got prev=%0d room=%0d",
                         evt_prev, evt_room);
            end else begin
                e = exp_q.pop_front();
                chk("evt_prev", evt_prev, e.prev);
                chk("evt_room", evt_room, e.rm);
                chk("evt_dwell", evt_dwell, e.dw);
            end
        end
    endtask

    initial begin
        foreach (m_visit[i]) m_visit[i] = 0;
        tbl[0] = '{3'd0, 1'b0, 1'b1};
        tbl[1] = '{3'd1, 1'b0, 1'b1};
        tbl[2] = '{3'd2, 1'b0, 1'b1};
        tbl[3] = '{3'd3, 1'b1, 1'b1};
        tbl[4] = '{3'd3, 1'b0, 1'b0};
        tbl[5] = '{3'd3, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset_n = 1'b1;

        // First room change after 5 cycles in Room0
        q_room = 3'd1;
        repeat (5) tick();
        room = 3'd1;
        tick();
        chk("t1_valid", evt_valid, 1);
        chk("t1_goal", goal_hit, 0);
        tick();
        chk("t1_fall", evt_valid, 0);
        chk("t1_visit1", q_count, 1);

        // Goal detection walk 0->1->2->3
        goal_room = 3'd3;
        for (int i = 0; i < 6; i++) begin
            room = tbl[i].room;
            tick();
            chk($sformatf("goal_row%0d", i), goal_hit, tbl[i].exp_goal);
            chk($sformatf("valid_row%0d", i), evt_valid, tbl[i].exp_valid);
        end

        // Held event and dropped event under backpressure
        room = 3'd0;
        tick();
        tick();
        evt_ready = 1'b0;
        room = 3'd1;
        tick();
        chk("hold_valid", evt_valid, 1);
        q_room  = 3'd2;
        room    = 3'd2;
        push_en = 1'b0;
        tick();
        push_en = 1'b1;
        chk("drop_ovf", evt_overflow, 1);
        chk("drop_valid", evt_valid, 1);
        repeat (2) tick();
        chk("hold_prev", evt_prev, 0);
        chk("hold_room", evt_room, 1);
        chk("hold_dwell", evt_dwell, 1);
        chk("visit2", q_count, 2);
        evt_ready = 1'b1;
        tick();
        chk("hs_fall", evt_valid, 0);
        chk("ovf_sticky", evt_overflow, 1);

        // Stuck detection at the dwell limit
        room = 3'd4;
        tick();
        while (m_dwell < LIM - 1) tick();
        chk("stuck_pre", stuck, 0);
        tick();
        chk("stuck_on", stuck, 1);
        room = 3'd6;
        tick();
        chk("stuck_off", stuck, 0);
        chk("stuck_dwell", evt_dwell, LIM);

        // Visit counter saturation, then clear with room change
        q_room = 3'd5;
        for (int i = 0; i < 300; i++) begin
            room = 3'd5;
            tick();
            room = 3'd6;
            tick();
        end
        tick();
        chk("q_sat", q_count, 255);
        clear = 1'b1;
        room  = 3'd3;
        tick();
        clear = 1'b0;
        chk("clr_valid", evt_valid, 0);
        chk("clr_ovf", evt_overflow, 0);
        chk("clr_goal", goal_hit, 0);
        for (int i = 0; i < 8; i++) begin
            q_room = 3'(i);
            tick();
            chk($sformatf("clr_cnt%0d", i), q_count, 0);
        end
        chk("clr_noevt", evt_valid, 0);

        // Asynchronous reset with an event pending
        evt_ready = 1'b0;
        room      = 3'd1;
        q_room    = 3'd1;
        tick();
        tick();
        chk("pre_rst_valid", evt_valid, 1);
        chk("pre_rst_prev", evt_prev, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        m_cur   = 3'd0;
        m_dwell = 0;
        foreach (m_visit[i]) m_visit[i] = 0;
        room      = 3'd0;
        evt_ready = 1'b1;
        #3;
        reset_n = 1'b1;
        tick();
        chk("post_rst_valid", evt_valid, 0);
        room = 3'd2;
        tick();
        chk("post_rst_evt", evt_valid, 1);
        tick();

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
